aes256_dec_key_sched: RTL and testbench

Sequential round-key scheduler for the AES-256 decryption path. It accepts a 256-bit cipher key and expands it into all 15 128-bit round keys by iterating the combinational `keyExpansion` stage once per cycle. It stores the round keys in a register file. It then streams them to the inverse-round datapath in decryption order (round key 14 down to 0), replaying the stored schedule for every block until a new key is loaded.

---
 rtl/aes256_pkg.sv | 42 ++++
 rtl/aes256_dec_key_sched_keyexp.sv | 43 ++++
 rtl/aes256_dec_key_sched.sv | 106 ++++++++++
 tb/tb_aes256_dec_key_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes256_pkg.sv
// Shared AES-256 types and GF(2^8) helpers for the decryption key scheduler.
// The S-box is computed (inverse + affine map) rather than tabulated.
package aes256_pkg;

  localparam int NR  = 14;
  localparam int NK  = 8;
  localparam int RKW = 128;

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

  typedef logic [0:14][127:0] rk_array_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes256_dec_key_sched_keyexp.sv
// One AES-256 key-expansion step: eight new schedule words from the previous eight.
// rc selects the round constant (1..7).
module keyExpansion
  import aes256_pkg::*;
(
  input  logic [3:0]   rc,
  input  logic [255:0] key,
  output logic [255:0] keyout
);

  logic [7:0]  rcon;
  logic [31:0] t, u;
  logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;

  always_comb begin
    case (rc)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  // The middle word of each 256-bit step gets SubWord without rotation or rcon.
  always_comb begin
    t  = sub_word({key[23:0], key[31:24]}) ^ {rcon, 24'h000000};
    n0 = key[255:224] ^ t;
    n1 = key[223:192] ^ n0;
    n2 = key[191:160] ^ n1;
    n3 = key[159:128] ^ n2;
    u  = sub_word(n3);
    n4 = key[127:96] ^ u;
    n5 = key[95:64] ^ n4;
    n6 = key[63:32] ^ n5;
    n7 = key[31:0] ^ n6;
    keyout = {n0, n1, n2, n3, n4, n5, n6, n7};
  end

endmodule

// File: rtl/aes256_dec_key_sched.sv
// AES-256 decryption round-key scheduler: expands a cipher key one step per cycle
// into a 15-entry register file, then replays round keys 14..0 for every block.
module aes256_dec_key_sched
  import aes256_pkg::*;
#(
  parameter int NR  = 14,
  parameter int RKW = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [255:0]   key,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [RKW-1:0] rk,
  output logic [3:0]     rk_idx,
  output logic           rk_last,
  output logic           busy
);

  localparam logic [3:0] LAST_IDX = 4'(NR);
  localparam logic [3:0] LAST_RC  = 4'(NR / 2);

  state_t       state, state_next;
  logic [3:0]   rc, ptr;
  logic [255:0] exp_q, exp_next;
  rk_array_t    rk_file;
  logic         at_top, key_load, rk_xfer;

  keyExpansion u_key_expansion (
    .rc     (rc),
    .key    (exp_q),
    .keyout (exp_next)
  );

  assign at_top   = (ptr == LAST_IDX);
  assign key_load = key_valid && key_ready;
  assign rk_xfer  = rk_valid && rk_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_valid) state_next = EXPAND;
      EXPAND:  if (rc == LAST_RC) state_next = SERVE;
      SERVE:   if (at_top && key_valid) state_next = EXPAND;
      default: state_next = IDLE;
    endcase
  end

  // A key offered at the start of a block wins over starting the next stream.
  always_comb begin
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    busy      = 1'b0;
    rk        = '0;
    rk_idx    = 4'd0;
    rk_last   = 1'b0;
    case (state)
      IDLE:   key_ready = 1'b1;
      EXPAND: busy = 1'b1;
      SERVE: begin
        key_ready = at_top;
        rk_valid  = !(at_top && key_valid);
        rk        = rk_file[ptr];
        rk_idx    = ptr;
        rk_last   = (ptr == 4'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc  <= 4'd0;
      ptr <= LAST_IDX;
    end else if (key_load) begin
      rc  <= 4'd1;
      ptr <= LAST_IDX;
    end else if (state == EXPAND) begin
      rc <= (rc == LAST_RC) ? 4'd0 : rc + 4'd1;
      if (rc == LAST_RC) ptr <= LAST_IDX;
    end else if (rk_xfer) begin
      ptr <= (ptr == 4'd0) ? LAST_IDX : ptr - 4'd1;
    end
  end

  // The last step only yields round key 14; its lower half has no slot.
  always_ff @(posedge clk) begin
    if (key_load) begin
      exp_q      <= key;
      rk_file[0] <= key[255:128];
      rk_file[1] <= key[127:0];
    end else if (state == EXPAND) begin
      exp_q <= exp_next;
      rk_file[{rc[2:0], 1'b0}] <= exp_next[255:128];
      if (rc != LAST_RC) rk_file[{rc[2:0], 1'b1}] <= exp_next[127:0];
    end
  end

endmodule

// File: tb/tb_aes256_dec_key_sched.sv
// Scoreboard bench for aes256_dec_key_sched: stimulus queues expected round keys,
// a monitor pops and compares them on every rk handshake.
module tb_aes256_dec_key_sched;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] val;
    logic         known;
  } exp_t;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2_KEY = 256'hffeeddccbbaa99887766554433221100_0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk, rst, key_valid, key_ready, rk_valid, rk_ready, rk_last, busy;
  logic [255:0] key;
  logic [127:0] rk;
  logic [3:0]   rk_idx;

  int           checks = 0;
  int           fails  = 0;
  exp_t         sb[$];
  logic [127:0] c3_rk [0:14];
  logic [127:0] exp_rk [0:14];
  logic         exp_known [0:14];
  int           exp_ptr = 14;

  aes256_dec_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setExpected(input logic [255:0] k, input bit full);
    for (int i = 0; i < 15; i++) begin
      exp_rk[i]    = full ? c3_rk[i] : 128'h0;
      exp_known[i] = full || (i < 2);
    end
    exp_rk[0] = k[255:128];
    exp_rk[1] = k[127:0];
    exp_ptr   = 14;
  endtask

  task automatic pushExpected(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx   = 4'(exp_ptr);
      e.val   = exp_rk[exp_ptr];
      e.known = exp_known[exp_ptr];
      sb.push_back(e);
      exp_ptr = (exp_ptr == 0) ? 14 : exp_ptr - 1;
    end
  endtask

  // Loads a key and checks the 7-cycle busy window; optionally pokes key_valid mid-expansion.
  task automatic applyStimulus(input logic [255:0] k, input logic rdy, input bit poke);
    key       = k;
    key_valid = 1'b1;
    rk_ready  = rdy;
    @(negedge clk);
    checkOutput("load_key_ready", key_ready, 1'b1);
    checkOutput("load_rk_valid", rk_valid, 1'b0);
    tick();
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (poke && i == 3) begin
        key       = ~k;
        key_valid = 1'b1;
      end
      @(negedge clk);
      checkOutput("expand_busy", busy, 1'b1);
      checkOutput("expand_rk_valid", rk_valid, 1'b0);
      if (poke && i == 3) checkOutput("expand_key_ready", key_ready, 1'b0);
      tick();
      key_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("first_rk_valid", rk_valid, 1'b1);
    checkOutput("first_busy", busy, 1'b0);
    checkOutput("first_rk_idx", rk_idx, 4'd14);
    tick();
  endtask

  task automatic runStream(input int n, input bit random_ready);
    int           done = 0;
    int           cycles = 0;
    bit           stalled = 0;
    logic [131:0] hold = '0;
    pushExpected(n);
    while (done < n && cycles < 400) begin
      rk_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stalled) checkOutput("stall_hold", {rk_idx, rk}, hold);
      if (!random_ready) checkOutput("stream_valid", rk_valid, 1'b1);
      if (rk_valid && rk_ready) begin
        done++;
        stalled = 0;
      end else if (rk_valid) begin
        stalled = 1;
        hold    = {rk_idx, rk};
      end else begin
        stalled = 0;
      end
      cycles++;
      tick();
    end
    rk_ready = 1'b0;
    if (done < n) begin
      checks++;
      fails++;
      $display("[TB] FAIL stream_timeout: got %0d transfers expected %0d", done, n);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rk_valid && rk_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL sb_underflow: got transfer idx %0d expected none", rk_idx);
      end else begin
        e = sb.pop_front();
        checkOutput("rk_idx", rk_idx, e.idx);
        if (e.known) checkOutput("rk_value", rk, e.val);
        checkOutput("rk_last", rk_last, e.idx == 4'd0);
      end
    end
  end

  initial begin
    c3_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    c3_rk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    c3_rk[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    c3_rk[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
    c3_rk[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
    c3_rk[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    c3_rk[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
    c3_rk[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
    c3_rk[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
    c3_rk[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
    c3_rk[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
    c3_rk[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
    c3_rk[12] = 128'h2541fe719bf500258813bbd55a721c0a;
    c3_rk[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    c3_rk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    rst       = 1'b1;
    key_valid = 1'b0;
    key       = '0;
    rk_ready  = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checkOutput("reset_key_ready", key_ready, 1'b1);
    checkOutput("reset_rk_valid", rk_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rk_idx", rk_idx, 4'd0);
    checkOutput("reset_rk_last", rk_last, 1'b0);
    tick();
    rst = 1'b0;

    $display("[TB] FIPS-197 C.3 key, key poke during expansion, continuous replay");
    applyStimulus(C3_KEY, 1'b0, 1'b1);
    setExpected(C3_KEY, 1'b1);
    runStream(30, 1'b0);

    $display("[TB] random rk_ready backpressure");
    runStream(20, 1'b1);
    runStream(10, 1'b1);

    $display("[TB] key offered mid-stream at ptr 7");
    runStream(7, 1'b0);
    key       = K2_KEY;
    key_valid = 1'b1;
    rk_ready  = 1'b1;
    pushExpected(1);
    @(negedge clk);
    checkOutput("midstream_key_ready", key_ready, 1'b0);
    checkOutput("midstream_rk_valid", rk_valid, 1'b1);
    tick();
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    runStream(7, 1'b0);

    $display("[TB] new key at block start with rk_ready high");
    applyStimulus(K2_KEY, 1'b1, 1'b0);
    setExpected(K2_KEY, 1'b0);
    runStream(15, 1'b0);

    $display("[TB] reset during expansion at rc 4");
    key       = C3_KEY;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_rk_valid", rk_valid, 1'b0);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_key_ready", key_ready, 1'b1);
    tick();
    applyStimulus(C3_KEY, 1'b0, 1'b0);
    setExpected(C3_KEY, 1'b1);
    runStream(15, 1'b1);

    repeat (3) tick();
    checkOutput("sb_drained", sb.size(), 0);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
